// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, drives the combinational
// instruction memory, and latches the returned word into the IF/ID register.
// Handles decode stalls, taken-branch redirect with one-bubble flush, and
// halts once the PC reaches the end of the program.
module fetch_stage #(
   parameter int Addr_W   = 8,
   parameter int byte_W   = 4,
   parameter int End_Addr = 68
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inp_stall,
   input  logic                  inp_branch_taken,
   input  logic [23:0]           inp_branch_imm24,
   input  logic [8*byte_W-1:0]   inp_instruction_data,
   output logic [Addr_W-1:0]     out_pc,
   output logic [8*byte_W-1:0]   out_ir,
   output logic [Addr_W-1:0]     out_ir_pc,
   output logic                  out_ir_valid,
   output logic                  out_halted
);

   localparam logic [Addr_W-1:0] END_A  = Addr_W'(End_Addr);
   localparam logic [Addr_W-1:0] STEP_A = Addr_W'(byte_W);
   localparam logic [Addr_W-1:0] EIGHT  = Addr_W'(8);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t                r_state;
   logic [Addr_W-1:0]     r_pc;
   logic [8*byte_W-1:0]   r_ir;
   logic [Addr_W-1:0]     r_ir_pc;
   logic                  r_ir_valid;
   logic                  r_halted;

   logic [Addr_W+25:0]    w_off_full;
   logic [Addr_W-1:0]     w_target;
   logic                  w_branch;

   // Branch target: word offset scaled to bytes, relative to the branch's PC + 8.
   // The adder is Addr_W wide so any wrap-around is silently truncated.
   always_comb begin
      w_off_full = {{Addr_W{inp_branch_imm24[23]}}, inp_branch_imm24, 2'b00};
      w_target   = r_ir_pc + EIGHT + w_off_full[Addr_W-1:0];
      // A branch flag is meaningless while the IR holds a bubble.
      w_branch   = inp_branch_taken & r_ir_valid;
   end

   // Fetch FSM: stall > branch redirect > end-of-program halt > sequential fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= RUN;
         r_pc       <= '0;
         r_ir       <= '0;
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (inp_stall) begin
                  // Freeze everything; a pending branch is re-presented by decode.
                  r_state <= RUN;
               end else if (w_branch) begin
                  // Redirect and squash the wrong-path word; IR PC is left alone.
                  r_pc       <= w_target;
                  r_ir       <= '0;
                  r_ir_valid <= 1'b0;
               end else if (r_pc >= END_A) begin
                  r_state    <= HALT;
                  r_halted   <= 1'b1;
                  r_ir       <= '0;
                  r_ir_valid <= 1'b0;
               end else begin
                  r_ir       <= inp_instruction_data;
                  r_ir_pc    <= r_pc;
                  r_ir_valid <= 1'b1;
                  r_pc       <= r_pc + STEP_A;
               end
            end
            HALT: begin
               // Parked until reset; stall and branch are don't-cares here.
               r_state <= HALT;
            end
            default: r_state <= HALT;
         endcase
      end
   end

   assign out_pc       = r_pc;
   assign out_ir       = r_ir;
   assign out_ir_pc    = r_ir_pc;
   assign out_ir_valid = r_ir_valid;
   assign out_halted   = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage. The driver applies inputs
// on the falling edge and queues the expected post-edge state; an independent
// monitor pops and checks #1 after each rising edge.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        br;
   logic [23:0] imm;
   logic [31:0] instr;
   logic [7:0]  pc;
   logic [31:0] ir;
   logic [7:0]  ir_pc;
   logic        ir_valid;
   logic        halted;

   typedef struct {
      logic [7:0]  pc;
      logic [7:0]  ir_pc;
      logic        v;
      logic        h;
      logic [31:0] ir;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   fetch_stage #(.Addr_W(8), .byte_W(4), .End_Addr(68)) dut (
      .clk                  (clk),
      .reset                (reset),
      .inp_stall            (stall),
      .inp_branch_taken     (br),
      .inp_branch_imm24     (imm),
      .inp_instruction_data (instr),
      .out_pc               (pc),
      .out_ir               (ir),
      .out_ir_pc            (ir_pc),
      .out_ir_valid         (ir_valid),
      .out_halted           (halted)
   );

   // Instruction memory contents: a distinct word per address, word 0 = E4121000.
   function automatic logic [31:0] word_at(input logic [7:0] a);
      return 32'hE4121000 + {24'h0, a} * 32'h01010101;
   endfunction

   assign instr = word_at(pc);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic rst, input logic st, input logic b,
                       input logic [23:0] im, input logic [7:0] e_pc,
                       input logic [7:0] e_irpc, input logic e_v, input logic e_h);
      exp_t e;
      @(negedge clk);
      reset = rst; stall = st; br = b; imm = im;
      e.pc = e_pc; e.ir_pc = e_irpc; e.v = e_v; e.h = e_h;
      e.ir = e_v ? word_at(e_irpc) : 32'h0;
      q.push_back(e);
   endtask

   // Monitor: check the oldest expectation just after each rising edge.
   initial begin
      exp_t e;
      bit   bad;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            bad = 1'b0;
            n_vec++;
            if (pc !== e.pc) begin
               $display("FAIL vec%0d pc: got %0d want %0d", n_vec, pc, e.pc); bad = 1'b1;
            end
            if (ir_pc !== e.ir_pc) begin
               $display("FAIL vec%0d ir_pc: got %0d want %0d", n_vec, ir_pc, e.ir_pc); bad = 1'b1;
            end
            if (ir_valid !== e.v) begin
               $display("FAIL vec%0d ir_valid: got %0b want %0b", n_vec, ir_valid, e.v); bad = 1'b1;
            end
            if (halted !== e.h) begin
               $display("FAIL vec%0d halted: got %0b want %0b", n_vec, halted, e.h); bad = 1'b1;
            end
            if (ir !== e.ir) begin
               $display("FAIL vec%0d ir: got %h want %h", n_vec, ir, e.ir); bad = 1'b1;
            end
            if (bad) n_bad++;
         end
      end
   end

   initial begin
      reset = 1'b1; stall = 1'b0; br = 1'b0; imm = 24'h0;
      // reset
      step(1, 0, 0, 0,     0,  0, 0, 0);
      step(1, 0, 0, 0,     0,  0, 0, 0);
      // first fetches
      step(0, 0, 0, 0,     4,  0, 1, 0);
      step(0, 0, 0, 0,     8,  4, 1, 0);
      step(0, 0, 0, 0,    12,  8, 1, 0);
      // stall two edges at pc=12
      step(0, 1, 0, 0,    12,  8, 1, 0);
      step(0, 1, 0, 0,    12,  8, 1, 0);
      step(0, 0, 0, 0,    16, 12, 1, 0);
      // run up to ir_pc=60
      for (int a = 16; a <= 60; a += 4)
         step(0, 0, 0, 0, 8'(a + 4), 8'(a), 1, 0);
      // stall + branch together: no change
      step(0, 1, 1, 24'hFFFFFB, 64, 60, 1, 0);
      // branch now taken: 60 + 8 - 20 = 48, flush
      step(0, 0, 1, 24'hFFFFFB, 48, 60, 0, 0);
      // branch while ir invalid: ignored, sequential fetch of 48
      step(0, 0, 1, 24'h000010, 52, 48, 1, 0);
      // run to end of program
      for (int a = 52; a <= 64; a += 4)
         step(0, 0, 0, 0, 8'(a + 4), 8'(a), 1, 0);
      step(0, 0, 0, 0,    68, 64, 0, 1);
      // halted: branch and stall ignored
      step(0, 0, 1, 24'hFFFFF0, 68, 64, 0, 1);
      step(0, 1, 0, 0,    68, 64, 0, 1);
      // reset during halt
      step(1, 1, 1, 24'hFFFFF0, 0, 0, 0, 0);
      step(0, 0, 0, 0,     4,  0, 1, 0);
      step(0, 0, 0, 0,     8,  4, 1, 0);
      // wrap: 4 + 8 - 16 = -4 -> 0xFC, then halt there
      step(0, 0, 1, 24'hFFFFFC, 8'hFC, 4, 0, 0);
      step(0, 0, 0, 0, 8'hFC,  4, 0, 1);
      // reset, run, then reset during a stall
      step(1, 0, 0, 0,     0,  0, 0, 0);
      step(0, 0, 0, 0,     4,  0, 1, 0);
      step(0, 0, 0, 0,     8,  4, 1, 0);
      step(0, 0, 0, 0,    12,  8, 1, 0);
      step(1, 1, 1, 24'hFFFFFB, 0, 0, 0, 0);
      step(0, 0, 0, 0,     4,  0, 1, 0);
      step(0, 0, 0, 0,     8,  4, 1, 0);
      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
         n_bad++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined datapath. Holds the program counter, drives the byte address into the combinational instruction memory, and registers the returned 32-bit word into the IF/ID instruction register. It also handles decode-stage stalls, taken branches (redirect plus flush) and program end (halt).

## Interface

Parameters:
- Addr_W, 8: PC and instruction-memory address width, in bits.
- byte_W, 4: instruction size in bytes; the instruction register is 8*byte_W bits wide.
- End_Addr, 68: first byte address past the program. Reaching it halts fetch.

Ports:
- clk  input  1: the single clock; all state updates on the rising edge.
- reset  input  1: synchronous, active-high reset.
- inp_stall  input  1: decode-stage hazard stall; freezes the whole stage.
- inp_branch_taken  input  1: the instruction in out_ir is a taken branch.
- inp_branch_imm24  input  24: signed word offset of that branch.
- inp_instruction_data  input  8*byte_W: word returned by instruction memory for out_pc, same cycle.
- out_pc  output  Addr_W: fetch address driven to instruction memory.
- out_ir  output  8*byte_W: IF/ID instruction register.
- out_ir_pc  output  Addr_W: address the out_ir word was fetched from.
- out_ir_valid  output  1: out_ir holds a real instruction rather than a bubble.
- out_halted  output  1: high while in HALT.

## Operation

- FSM has two states, RUN and HALT. Every output is registered.
- On reset: state=RUN, out_pc=0, out_ir=0, out_ir_pc=0, out_ir_valid=0, out_halted=0.
- Branch qualification: inp_branch_taken counts only when out_ir_valid=1.
- Branch target: out_ir_pc + 8 + (sign_extend(inp_branch_imm24) << 2), truncated modulo 2^Addr_W. Wrap-around is silent.
- In RUN, each edge applies the first matching rule:
  1. inp_stall=1: all registers hold. A simultaneous branch is ignored this cycle; decode holds it and it is re-evaluated next cycle.
  2. Qualified branch: out_pc <= target, out_ir <= 0, out_ir_valid <= 0. This flushes the wrong-path word. out_ir_pc holds.
  3. out_pc >= End_Addr: state <= HALT, out_halted <= 1, out_ir_valid <= 0, out_ir <= 0. out_pc holds.
  4. Otherwise (normal fetch): out_ir <= inp_instruction_data, out_ir_pc <= out_pc, out_ir_valid <= 1, out_pc <= out_pc + byte_W (mod 2^Addr_W).
- A branch at the same edge as the End_Addr check takes priority over halting. A branch target >= End_Addr halts on the following edge.
- HALT:
  - All registers hold; stall and branch inputs are ignored.
  - Only reset leaves HALT.
- Reset has priority over every other input in every state, including mid-stall and mid-branch.

## Timing

- The memory read is combinational. The word at address A appears on out_ir one edge after out_pc==A.
- Throughput is one instruction per cycle when unstalled.
- Taken-branch penalty is one bubble: the flush edge gives out_ir_valid=0, and the next edge captures the target word.
- Stall has zero-cycle response: the edge where inp_stall=1 changes nothing.
- The first valid out_ir appears one edge after reset deasserts.

## Test plan

- Reset then run: with reset released and memory word 0 = 0xE4121000, the first edge gives out_ir=0xE4121000, out_ir_pc=0, out_ir_valid=1, out_pc=4. The next edge gives out_ir_pc=4, out_pc=8.
- Stall: hold inp_stall=1 for 2 edges with out_pc=12. out_pc, out_ir and out_ir_pc stay unchanged. After release, the next edge gives out_ir_pc=12, out_pc=16.
- Taken branch: with out_ir_pc=60, out_ir_valid=1, inp_branch_taken=1 and imm24=0xFFFFFB, the edge gives out_pc=48, out_ir_valid=0. The next edge gives out_ir_pc=48, out_ir_valid=1, out_pc=52.
- Stall plus branch in the same cycle: nothing changes. The following unstalled edge gives the redirect to 48. A branch presented while out_ir_valid=0 is ignored and fetch continues sequentially.
- Wrap and halt: out_ir_pc=4 with imm24=0xFFFFFC gives target 0xFC (>= 68), so the next edge gives out_halted=1, out_ir_valid=0, out_pc=0xFC. A straight run from 0 ends with out_ir_pc=64 captured, then out_halted=1 with out_pc=68. Later branches and stalls have no effect.
- Reset mid-operation: assert reset during a stall and again during HALT. Each time, the next edge gives out_pc=0, out_ir=0, out_ir_valid=0, out_halted=0, and fetch restarts from 0.
